// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU for the execute stage.
// Single-cycle ops (AND/OR/ADD/SUB/PASS-B/LSL/LSR/undefined) register their
// result on the accepting edge; MUL runs an N-iteration shift-add loop.
// At most one operation is in flight; the result is held until consumed.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-low reset
//   in_valid    operation request          in_ready   block can accept
//   a, b        operands (shift amount is b[SW-1:0])
//   ALUControl  4-bit opcode
//   out_valid   result and flags valid     out_ready  consumer takes result
//   result      registered result
//   zero, negative, carry, overflow   NZCV flags for result
module alu_seq #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int unsigned SW = $clog2(N);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpPass = 4'b0111;
  localparam logic [3:0] OpMul  = 4'b1000;
  localparam logic [3:0] OpLsl  = 4'b1001;
  localparam logic [3:0] OpLsr  = 4'b1010;

  localparam logic [SW-1:0] CntLast = SW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          negative_q, negative_d;
  logic          carry_q, carry_d;
  logic          overflow_q, overflow_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;

  // Single-cycle datapath, evaluated on the current (unregistered) inputs.
  logic          is_sub;
  logic [N-1:0]  b_eff;
  logic [N:0]    sum;
  logic [SW-1:0] shamt;
  logic [N-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;
  logic [N-1:0]  acc_step;

  always_comb begin
    is_sub = (ALUControl == OpSub);
    // SUB is a + ~b + 1, so carry reads as NOT borrow.
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    shamt  = b[SW-1:0];
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (ALUControl)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpAdd, OpSub: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
      end
      OpPass: alu_res = b;
      OpLsl:  alu_res = a << shamt;
      OpLsr:  alu_res = a >> shamt;
      default: alu_res = {N{1'b1}};
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (ALUControl == OpMul) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            negative_d = alu_res[N-1];
            carry_d    = alu_c;
            overflow_d = alu_v;
            state_d    = StHold;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed N iterations; no early exit when the multiplier runs out.
        if (cnt_q == CntLast) begin
          result_d   = acc_step;
          zero_d     = (acc_step == '0);
          negative_d = acc_step[N-1];
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: one N=8 and one N=64 instance share the
// stimulus bus; a select flag routes handshakes and observed outputs.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a, b;
  logic [3:0]  op;
  logic        iv, ordy;
  logic        use8;

  logic        in_ready8, out_valid8, zero8, neg8, carry8, ovf8;
  logic [7:0]  res8;
  logic        in_ready64, out_valid64, zero64, neg64, carry64, ovf64;
  logic [63:0] res64;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(8)) u_d8 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv & use8),
    .in_ready   (in_ready8),
    .a          (a[7:0]),
    .b          (b[7:0]),
    .ALUControl (op),
    .out_valid  (out_valid8),
    .out_ready  (ordy & use8),
    .result     (res8),
    .zero       (zero8),
    .negative   (neg8),
    .carry      (carry8),
    .overflow   (ovf8)
  );

  alu_seq #(.N(64)) u_d64 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv & ~use8),
    .in_ready   (in_ready64),
    .a          (a),
    .b          (b),
    .ALUControl (op),
    .out_valid  (out_valid64),
    .out_ready  (ordy & ~use8),
    .result     (res64),
    .zero       (zero64),
    .negative   (neg64),
    .carry      (carry64),
    .overflow   (ovf64)
  );

  logic        o_rdy, o_vld, o_z, o_n, o_c, o_v;
  logic [63:0] o_res;
  assign o_rdy = use8 ? in_ready8  : in_ready64;
  assign o_vld = use8 ? out_valid8 : out_valid64;
  assign o_res = use8 ? {56'd0, res8} : res64;
  assign o_z   = use8 ? zero8 : zero64;
  assign o_n   = use8 ? neg8  : neg64;
  assign o_c   = use8 ? carry8 : carry64;
  assign o_v   = use8 ? ovf8  : ovf64;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: arithmetic straight from the opcode table, on w-bit values.
  function automatic void model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                input logic [3:0] opc, output logic [63:0] r,
                                output logic c, output logic v);
    logic [63:0]  m, x, y;
    logic [64:0]  s;
    logic [127:0] p;
    int           sh;
    m  = wmask(w);
    x  = ai & m;
    y  = bi & m;
    sh = int'(y % 64'(w));
    c  = 1'b0;
    v  = 1'b0;
    case (opc)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[63:0] & m;
        c = s[w];
        v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'b0110: begin
        r = (x - y) & m;
        c = (x >= y);
        v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'b0111: r = y;
      4'b1000: begin
        p = {64'd0, x} * {64'd0, y};
        r = p[63:0] & m;
      end
      4'b1001: r = (x << sh) & m;
      4'b1010: r = x >> sh;
      default: r = m;
    endcase
  endfunction

  // Issue one op on the selected instance, check latency, outputs, stability
  // under `hold` cycles of backpressure (with ignored requests), and release.
  task automatic run_op(input int w, input logic [63:0] ai, input logic [63:0] bi,
                        input logic [3:0] opc, input int hold, input string tag);
    logic [63:0] er;
    logic        ec, ev;
    int          cyc;
    int          lat;
    use8 = (w == 8);
    model(w, ai, bi, opc, er, ec, ev);
    lat = (opc == 4'b1000) ? w + 1 : 1;
    @(negedge clk);
    check({tag, ".in_ready"}, {63'd0, o_rdy}, 64'd1);
    a  = ai;
    b  = bi;
    op = opc;
    iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    op = 4'($urandom);
    cyc = 1;
    while (!o_vld && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".result"}, o_res, er);
    check({tag, ".zcnv"}, {60'd0, o_z, o_n, o_c, o_v},
          {60'd0, (er == 64'd0), er[w-1], ec, ev});
    for (int i = 0; i < hold; i++) begin
      iv = 1'b1;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 4'b0010;
      @(negedge clk);
      check({tag, ".hold"}, {o_res[61:0], o_vld, o_rdy}, {er[61:0], 1'b1, 1'b0});
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check({tag, ".release"}, {62'd0, o_vld, o_rdy}, 64'd1);
    check({tag, ".kept"}, o_res, er);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ctl"}, {62'd0, o_rdy, o_vld}, 64'd2);
    check({tag, ".result"}, o_res, 64'd0);
    check({tag, ".zcnv"}, {60'd0, o_z, o_n, o_c, o_v}, 64'h8);
  endtask

  logic [3:0] legal_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  ro;
    int          w;
    int          seen;
    reset = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    use8  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    use8 = 1'b1;
    #0 check_reset_vals("rst8");
    use8 = 1'b0;
    #0 check_reset_vals("rst64");
    reset = 1'b1;

    // Directed vectors.
    run_op(8, 64'h7F, 64'h01, 4'b0010, 0, "add_ovf");
    run_op(8, 64'hFF, 64'h01, 4'b0010, 0, "add_wrap");
    run_op(64, 64'd5, 64'd5, 4'b0110, 0, "sub_eq");
    run_op(64, 64'd3, 64'd5, 4'b0110, 0, "sub_borrow");
    run_op(8, 64'd13, 64'd11, 4'b1000, 0, "mul13x11");
    run_op(8, 64'h10, 64'h10, 4'b1000, 0, "mul_wrap");
    run_op(64, 64'd1, 64'd63, 4'b1001, 5, "lsl_bp");
    run_op(64, 64'h8000_0000_0000_0000, 64'hFFC0, 4'b1010, 0, "lsr_hi_b");
    run_op(8, 64'hA5, 64'd0, 4'b1001, 0, "lsl0");
    run_op(8, 64'hA5, 64'd7, 4'b1010, 0, "lsr7");
    run_op(64, 64'h1234, 64'h5678, 4'b1111, 0, "illegal");
    run_op(64, {$urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 1, "mul64");

    // Randomized ops on both widths.
    for (int i = 0; i < 60; i++) begin
      w  = (i % 2 == 0) ? 8 : 64;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 5))
        0: rb[5:0] = 6'd0;
        1: rb[5:0] = 6'(w - 1);
        default: ;
      endcase
      run_op(w, ra, rb, ro, $urandom_range(0, 2), "rand");
    end

    // Reset in the middle of an N=8 multiply.
    use8 = 1'b1;
    @(negedge clk);
    a  = 64'd13;
    b  = 64'd11;
    op = 4'b1000;
    iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_mul_rst");
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_vld) seen = 1;
    end
    check("mid_mul_no_valid", 64'(seen), 64'd0);
    check("mid_mul_idle", {63'd0, o_rdy}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the datapath's single-cycle ALU.
- Keeps the existing opcode set and encodings: AND, OR, ADD, SUB, PASS-B, and all-ones for undefined codes.
- Adds the following:
  - width parameter plus derived shift-amount width;
  - a multi-cycle shift-add multiply;
  - logical shifts;
  - full NZCV flag generation.
- Sits in the execute stage of the multi-cycle core: the control FSM issues operations with valid/ready and consumes results with valid/ready.

Parameters:
- N, 64, operand and result width in bits (N >= 4, power of two).
- SW, $clog2(N), shift-amount width and multiply cycle-counter width (derived; not overridden).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk; 0 = reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- a  input  N  operand A.
- b  input  N  operand B (shift amount is b[SW-1:0]).
- ALUControl  input  4  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  N  registered result.
- zero  output  1  result == 0.
- negative  output  1  result[N-1].
- carry  output  1  carry-out (ADD); NOT borrow (SUB); else 0.
- overflow  output  1  signed overflow (ADD/SUB); else 0.

Behaviour:

Reset
- reset==0 at a rising edge:
  - state=IDLE, in_ready=1, out_valid=0;
  - result=0, zero=1, negative=0, carry=0, overflow=0;
  - multiply counter and accumulators = 0.
- Reset mid-multiply or mid-hold aborts the operation; no out_valid is ever produced for it.

Opcodes
- 0000 a&b
- 0001 a|b
- 0010 a+b
- 0110 a-b (a + ~b + 1)
- 0111 b
- 1000 MUL: low N bits of unsigned a*b
- 1001 LSL: a << b[SW-1:0]
- 1010 LSR: a >> b[SW-1:0], zero-fill
- Any other code: result = all ones, carry=0, overflow=0.

Flags
- zero and negative are computed from the final result for every opcode.
- carry for ADD = bit N of the (N+1)-bit sum.
- overflow for ADD = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]).
- SUB uses the same carry and overflow rules with ~b in place of b.

State machine: IDLE, MUL, HOLD
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, a, b and ALUControl are captured.
  - Non-MUL opcode: result and flags are registered on that same edge; go to HOLD.
  - MUL opcode: multiplicand=a, multiplier=b, accumulator=0, counter=0; go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: if multiplier[0], accumulator += multiplicand (mod 2^N); multiplicand <<= 1; multiplier >>= 1; counter++.
  - After exactly N iterations (counter==N-1 on the last), register result=accumulator and its flags; go to HOLD.
  - No early termination.
- HOLD:
  - out_valid=1; in_ready=0.
  - result and flags stay stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - in_ready rises the next cycle; there is no same-cycle re-issue.

Latency
- Non-MUL: out_valid is asserted 1 cycle after acceptance.
- MUL: out_valid is asserted N+1 cycles after acceptance.
- Throughput: at most one operation in flight. Non-MUL back-to-back with out_ready held at 1 gives one result per 2 cycles.

Handshake and boundary rules
- in_valid, a, b and ALUControl are ignored while in_ready=0; inputs are not required to be held after acceptance.
- Outputs only change on acceptance or reset.
- Shift by 0 returns a.
- Shift by N-1 keeps a single bit.
- Shift counts use only b[SW-1:0]; upper bits of b are ignored.
- MUL overflow beyond N bits is discarded silently; carry and overflow are 0 for MUL.
- Addition wraps mod 2^N.

Test Plan:
- Reset then hold: reset=0 for 2 cycles then 1 -> in_ready=1, out_valid=0, result=0, zero=1, negative=0, carry=0, overflow=0.
- ADD, N=8: a=0x7F, b=0x01, op 0010 -> one cycle later out_valid=1, result=0x80, negative=1, overflow=1, carry=0.
- ADD wrap, N=8: a=0xFF, b=0x01, op 0010 -> result=0x00, zero=1, carry=1, overflow=0.
- SUB, N=64: a=5, b=5, op 0110 -> result=0, zero=1, carry=1.
- SUB with borrow, N=64: a=3, b=5, op 0110 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
- MUL, N=8: a=13, b=11, op 1000 -> out_valid exactly 9 cycles after accept, result=0x8F (143). Repeat with a=0x10, b=0x10 -> result=0x00, zero=1.
- Backpressure: out_ready=0 for 5 cycles after a LSL with a=0x1, b=63, N=64 -> result=0x8000_0000_0000_0000 held stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> in_ready=1 the next cycle.
- Reset mid-MUL: assert reset=0 on cycle 3 of an N=8 MUL -> no out_valid is produced, and all outputs return to reset values.
- Illegal opcode: op 1111 -> result=all ones, carry=0, overflow=0.
